// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch/decode FSM driving one-hot datapath strobes per T-step.
// Outputs are a Moore decode of the state and IR opcode; ConFFQ gates PCin combinationally in br T6.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConFFQ,
    input  logic        Stop,
    output logic        ClearDP,
    output logic        Run,
    output logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite,
    output logic        IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
    output logic        CSEout, Gra, Grb, Grc, Rin, Rout, BAout, CONin, InPortout, OutPortin,
    output logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

    state_t     state_q;
    state_t     last_state;
    logic [4:0] opc;
    logic       ir_unused;
    logic       is_reg_alu, is_imm, is_mem, is_muldiv, is_negnot;
    logic       op_en;

    assign opc        = IR[31:27];
    assign ir_unused  = ^IR[26:0];
    assign is_reg_alu = (opc >= OP_ADD) && (opc <= OP_ROL);
    assign is_imm     = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_LDI);
    assign is_mem     = (opc == OP_LD) || (opc == OP_ST);
    assign is_muldiv  = (opc == OP_MUL) || (opc == OP_DIV);
    assign is_negnot  = (opc == OP_NEG) || (opc == OP_NOT);

    always_comb begin
        last_state = S_T3;
        if (is_mem)                                    last_state = S_T7;
        else if (is_muldiv || opc == OP_BR)            last_state = S_T6;
        else if (is_reg_alu || is_imm)                 last_state = S_T5;
        else if (is_negnot || opc == OP_JAL)           last_state = S_T4;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RESET;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_T0;
                S_T0:    state_q <= S_T1;
                S_T1:    state_q <= S_T2;
                S_T2:    state_q <= S_T3;
                S_HALT:  state_q <= S_HALT;
                default: begin
                    if (state_q == S_T3 && opc == OP_HALT)
                        state_q <= S_HALT;
                    else if (state_q == last_state)
                        state_q <= Stop ? S_HALT : S_T0;
                    else
                        state_q <= state_t'(state_q + 4'd1);
                end
            endcase
        end
    end

    // op_en marks the single step where the ALU operation select is driven; opcode picks which.
    assign ADD  = op_en && (opc == OP_ADD || opc == OP_ADDI || opc == OP_LDI || is_mem || opc == OP_BR);
    assign SUB  = op_en && (opc == OP_SUB);
    assign AND  = op_en && (opc == OP_AND || opc == OP_ANDI);
    assign OR   = op_en && (opc == OP_OR  || opc == OP_ORI);
    assign SHR  = op_en && (opc == OP_SHR);
    assign SHRA = op_en && (opc == OP_SHRA);
    assign SHL  = op_en && (opc == OP_SHL);
    assign ROR  = op_en && (opc == OP_ROR);
    assign ROL  = op_en && (opc == OP_ROL);
    assign MUL  = op_en && (opc == OP_MUL);
    assign DIV  = op_en && (opc == OP_DIV);
    assign NEG  = op_en && (opc == OP_NEG);
    assign NOT  = op_en && (opc == OP_NOT);

    assign ClearDP = (state_q == S_RESET);
    assign Run     = (state_q != S_RESET) && (state_q != S_HALT);

    always_comb begin
        {PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite} = '0;
        {IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout} = '0;
        {CSEout, Gra, Grb, Grc, Rin, Rout, BAout, CONin, InPortout, OutPortin}    = '0;
        op_en = 1'b0;
        case (state_q)
            S_T0: {PCout, MARin, IncPC, Zlowin} = '1;
            S_T1: {Zlowout, PCin, MDMuxread, RAMread, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                if (is_reg_alu || (is_imm && opc != OP_LDI)) {Grb, Rout, Yin} = '1;
                else if (is_mem || opc == OP_LDI)         {Grb, BAout, Yin} = '1;
                else if (is_muldiv)                       {Gra, Rout, Yin} = '1;
                else if (is_negnot)                       {Grb, Rout, op_en, Zlowin} = '1;
                else if (opc == OP_BR)                    {Gra, Rout, CONin} = '1;
                else if (opc == OP_JR)                    {Gra, Rout, PCin} = '1;
                else if (opc == OP_JAL)                   {PCout, Grb, Rin} = '1;
                else if (opc == OP_IN)                    {InPortout, Gra, Rin} = '1;
                else if (opc == OP_OUT)                   {Gra, Rout, OutPortin} = '1;
                else if (opc == OP_MFHI)                  {HIout, Gra, Rin} = '1;
                else if (opc == OP_MFLO)                  {LOout, Gra, Rin} = '1;
            end
            S_T4: begin
                if (is_reg_alu)                 {Grc, Rout, op_en, Zlowin} = '1;
                else if (is_imm || is_mem)      {CSEout, op_en, Zlowin} = '1;
                else if (is_muldiv)             {Grb, Rout, op_en, Zhighin, Zlowin} = '1;
                else if (is_negnot)             {Zlowout, Gra, Rin} = '1;
                else if (opc == OP_BR)          {PCout, Yin} = '1;
                else if (opc == OP_JAL)         {Gra, Rout, PCin} = '1;
            end
            S_T5: begin
                if (is_reg_alu || is_imm)       {Zlowout, Gra, Rin} = '1;
                else if (is_mem)                {Zlowout, MARin} = '1;
                else if (is_muldiv)             {Zlowout, LOin} = '1;
                else if (opc == OP_BR)          {CSEout, op_en, Zlowin} = '1;
            end
            S_T6: begin
                if (opc == OP_LD)               {MDMuxread, RAMread, MDRin} = '1;
                else if (opc == OP_ST)          {Gra, Rout, MDRin} = '1;
                else if (is_muldiv)             {Zhighout, HIin} = '1;
                else if (opc == OP_BR) begin
                    Zlowout = 1'b1;
                    PCin    = ConFFQ;
                end
            end
            S_T7: begin
                if (opc == OP_LD)               {MDRout, Gra, Rin} = '1;
                else if (opc == OP_ST)          RAMwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven check of control_sequencer strobes per T-step, plus halt/stop/async-clear sequences.
module tb_control_sequencer;

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic ConFFQ = 1'b0;
    logic Stop = 1'b0;
    logic ClearDP, Run, PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite;
    logic IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic CSEout, Gra, Grb, Grc, Rin, Rout, BAout, CONin, InPortout, OutPortin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .ConFFQ(ConFFQ), .Stop(Stop),
        .ClearDP(ClearDP), .Run(Run), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite),
        .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .CSEout(CSEout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
    );

    logic [43:0] obs;
    assign obs = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD,
                  OutPortin, InPortout, CONin, BAout, Rout, Rin, Grc, Grb, Gra, CSEout,
                  LOout, HIout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin, IRin,
                  RAMwrite, RAMread, MDMuxread, MDRout, MDRin, MARin, IncPC, PCout, PCin, Run, ClearDP};

    localparam logic [43:0] M_CLEARDP = 44'd1 << 0,  M_RUN      = 44'd1 << 1,  M_PCIN     = 44'd1 << 2;
    localparam logic [43:0] M_PCOUT   = 44'd1 << 3,  M_INCPC    = 44'd1 << 4,  M_MARIN    = 44'd1 << 5;
    localparam logic [43:0] M_MDRIN   = 44'd1 << 6,  M_MDROUT   = 44'd1 << 7,  M_MDMUX    = 44'd1 << 8;
    localparam logic [43:0] M_RAMRD   = 44'd1 << 9,  M_RAMWR    = 44'd1 << 10, M_IRIN     = 44'd1 << 11;
    localparam logic [43:0] M_YIN     = 44'd1 << 12, M_ZLOIN    = 44'd1 << 13, M_ZHIIN    = 44'd1 << 14;
    localparam logic [43:0] M_ZLOOUT  = 44'd1 << 15, M_ZHIOUT   = 44'd1 << 16, M_HIIN     = 44'd1 << 17;
    localparam logic [43:0] M_LOIN    = 44'd1 << 18, M_HIOUT    = 44'd1 << 19, M_LOOUT    = 44'd1 << 20;
    localparam logic [43:0] M_CSEOUT  = 44'd1 << 21, M_GRA      = 44'd1 << 22, M_GRB      = 44'd1 << 23;
    localparam logic [43:0] M_GRC     = 44'd1 << 24, M_RIN      = 44'd1 << 25, M_ROUT     = 44'd1 << 26;
    localparam logic [43:0] M_BAOUT   = 44'd1 << 27, M_CONIN    = 44'd1 << 28, M_INPORT   = 44'd1 << 29;
    localparam logic [43:0] M_OUTPORT = 44'd1 << 30, M_ADD      = 44'd1 << 31, M_SUB      = 44'd1 << 32;
    localparam logic [43:0] M_MUL     = 44'd1 << 33, M_DIV      = 44'd1 << 34, M_AND      = 44'd1 << 35;
    localparam logic [43:0] M_OR      = 44'd1 << 36, M_SHR      = 44'd1 << 37, M_SHRA     = 44'd1 << 38;
    localparam logic [43:0] M_SHL     = 44'd1 << 39, M_ROR      = 44'd1 << 40, M_ROL      = 44'd1 << 41;
    localparam logic [43:0] M_NEG     = 44'd1 << 42, M_NOT      = 44'd1 << 43;

    localparam logic [43:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN;
    localparam logic [43:0] F1 = M_RUN | M_ZLOOUT | M_PCIN | M_MDMUX | M_RAMRD | M_MDRIN;
    localparam logic [43:0] F2 = M_RUN | M_MDROUT | M_IRIN;

    typedef struct {
        logic [31:0]      ir;
        logic             cff;
        int               len;
        logic [4:0][43:0] exp;
        string            name;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] ir, input logic cff, input int len,
                                input logic [43:0] t3, input logic [43:0] t4, input logic [43:0] t5,
                                input logic [43:0] t6, input logic [43:0] t7, input string name);
        vec_t v;
        v.ir = ir; v.cff = cff; v.len = len; v.name = name;
        v.exp = {t7, t6, t5, t4, t3};
        return v;
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Sample each step at the falling edge; IR/ConFFQ/Stop change during T0, which is opcode-independent.
    task automatic run_instr(input vec_t v, input logic stop);
        logic [43:0] e;
        for (int c = 0; c < v.len; c++) begin
            @(negedge clock);
            case (c)
                0: e = F0;
                1: e = F1;
                2: e = F2;
                default: e = v.exp[c-3];
            endcase
            check($sformatf("%s_T%0d", v.name, c), obs, e);
            if (c == 0) begin
                IR = v.ir;
                ConFFQ = v.cff;
                Stop = stop;
            end
        end
    endtask

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    initial begin
        vec_t v;
        tbl[0]  = mk(32'h61A7FFFB, 0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_CSEOUT|M_ADD|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "addi");
        tbl[1]  = mk(32'h00800010, 0, 8, M_RUN|M_GRB|M_BAOUT|M_YIN, M_RUN|M_CSEOUT|M_ADD|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_MARIN, M_RUN|M_MDMUX|M_RAMRD|M_MDRIN, M_RUN|M_MDROUT|M_GRA|M_RIN, "ld");
        tbl[2]  = mk(32'h10800020, 0, 8, M_RUN|M_GRB|M_BAOUT|M_YIN, M_RUN|M_CSEOUT|M_ADD|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_MARIN, M_RUN|M_GRA|M_ROUT|M_MDRIN, M_RUN|M_RAMWR, "st");
        tbl[3]  = mk(32'h98000004, 0, 7, M_RUN|M_GRA|M_ROUT|M_CONIN, M_RUN|M_PCOUT|M_YIN,
                     M_RUN|M_CSEOUT|M_ADD|M_ZLOIN, M_RUN|M_ZLOOUT, 0, "br_c0");
        tbl[4]  = mk(32'h98000004, 1, 7, M_RUN|M_GRA|M_ROUT|M_CONIN, M_RUN|M_PCOUT|M_YIN,
                     M_RUN|M_CSEOUT|M_ADD|M_ZLOIN, M_RUN|M_ZLOOUT|M_PCIN, 0, "br_c1");
        tbl[5]  = mk(32'h18000000, 0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_ADD|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "add");
        tbl[6]  = mk(32'h40000000, 0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_SHRA|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "shra");
        tbl[7]  = mk(32'h58000000, 0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_ROL|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "rol");
        tbl[8]  = mk(32'h70000000, 0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_CSEOUT|M_OR|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "ori");
        tbl[9]  = mk(32'h08000000, 0, 6, M_RUN|M_GRB|M_BAOUT|M_YIN, M_RUN|M_CSEOUT|M_ADD|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_GRA|M_RIN, 0, 0, "ldi");
        tbl[10] = mk(32'h80000000, 0, 7, M_RUN|M_GRA|M_ROUT|M_YIN, M_RUN|M_GRB|M_ROUT|M_MUL|M_ZHIIN|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_LOIN, M_RUN|M_ZHIOUT|M_HIIN, 0, "mul");
        tbl[11] = mk(32'h78000000, 0, 7, M_RUN|M_GRA|M_ROUT|M_YIN, M_RUN|M_GRB|M_ROUT|M_DIV|M_ZHIIN|M_ZLOIN,
                     M_RUN|M_ZLOOUT|M_LOIN, M_RUN|M_ZHIOUT|M_HIIN, 0, "div");
        tbl[12] = mk(32'h88000000, 0, 5, M_RUN|M_GRB|M_ROUT|M_NEG|M_ZLOIN, M_RUN|M_ZLOOUT|M_GRA|M_RIN,
                     0, 0, 0, "neg");
        tbl[13] = mk(32'hA8000000, 0, 5, M_RUN|M_PCOUT|M_GRB|M_RIN, M_RUN|M_GRA|M_ROUT|M_PCIN, 0, 0, 0, "jal");
        tbl[14] = mk(32'hA0000000, 0, 4, M_RUN|M_GRA|M_ROUT|M_PCIN, 0, 0, 0, 0, "jr");
        tbl[15] = mk(32'hB8000000, 0, 4, M_RUN|M_GRA|M_ROUT|M_OUTPORT, 0, 0, 0, 0, "out");
        tbl[16] = mk(32'hC0000000, 0, 4, M_RUN|M_HIOUT|M_GRA|M_RIN, 0, 0, 0, 0, "mfhi");
        tbl[17] = mk(32'hF0000000, 0, 4, M_RUN, 0, 0, 0, 0, "unlisted");

        @(negedge clock);
        check("reset_held", obs, M_CLEARDP);
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        check("reset_one_cycle", obs, M_CLEARDP);

        for (int i = 0; i < NVEC; i++) run_instr(tbl[i], 1'b0);

        // Stop held from T0 must only act at the last step of add.
        v = tbl[5];
        v.name = "add_stop";
        run_instr(v, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("halt_hold%0d", k), obs, 44'd0);
        end
        Stop = 1'b0;
        #2 clear = 1'b0;
        #1 check("halt_clear_async", obs, M_CLEARDP);
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        check("halt_reset_cycle", obs, M_CLEARDP);

        // Clear during ld T6 drops the strobes without waiting for a clock edge.
        v = tbl[1];
        v.len = 7;
        v.name = "ld_abort";
        run_instr(v, 1'b0);
        #2 clear = 1'b0;
        #1 check("ld_abort_async", obs, M_CLEARDP);
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        check("ld_abort_reset", obs, M_CLEARDP);

        v = mk(32'hD8000000, 0, 4, M_RUN, 0, 0, 0, 0, "halt_op");
        run_instr(v, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("halt_op_hold%0d", k), obs, 44'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit Mini SRC datapath. It replaces the per-instruction stimulus sequences with an FSM. The FSM fetches an instruction, decodes the IR opcode, and drives the datapath's one-hot control inputs for each T-step. It sits beside `Datapath`: its outputs connect to that module's control ports, and it reads back `IR` and `ConFFQ`.

## Interface
- No parameters. Opcode map and step sequences are fixed.
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-low reset
- IR  in  32  datapath instruction register; opcode = IR[31:27]
- ConFFQ  in  1  branch condition flip-flop from the datapath
- Stop  in  1  halt request, sampled at the last step of each instruction
- ClearDP  out  1  datapath clear, active-high
- Run  out  1  high while executing instructions
- PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout, CONin, InPortout, OutPortin  out  1 each  datapath controls
- ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  out  1 each  ALU operation selects

## Operation
- Opcodes: 00000 ld, 00001 ldi, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01100 addi, 01101 andi, 01110 ori, 01111 div, 10000 mul, 10001 neg, 10010 not, 10011 br, 10100 jr, 10101 jal, 10110 in, 10111 out, 11000 mfhi, 11001 mflo, 11010 nop, 11011 halt. Unlisted opcodes (11100–11111) execute as nop.
- States: RESET, T0..T7, HALT.
- RESET: ClearDP=1, all other outputs 0.
- Fetch, common to every instruction:
  - T0: PCout MARin IncPC Zlowin
  - T1: Zlowout PCin MDMuxread RAMread MDRin
  - T2: MDRout IRin
- T3 onward, decoded from IR[31:27]:
  - Register ALU ops (add..rol): T3 Grb Rout Yin; T4 Grc Rout op Zlowin; T5 Zlowout Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 CSEout op Zlowin (op is ADD/AND/OR); T5 Zlowout Gra Rin.
  - ldi: same as addi, but T3 uses BAout instead of Rout.
  - ld: T3 Grb BAout Yin; T4 CSEout ADD Zlowin; T5 Zlowout MARin; T6 MDMuxread RAMread MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin (MDMuxread=0); T7 RAMwrite.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout op Zhighin Zlowin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 Grb Rout op Zlowin; T4 Zlowout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 CSEout ADD Zlowin; T6 Zlowout, with PCin = ConFFQ.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout Grb Rin (link register is the Rb field); T4 Gra Rout PCin.
  - in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin.
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
  - nop: T3 with no outputs asserted.
  - halt: T3 moves to HALT.
- Last step of an instruction: go to HALT if Stop=1, otherwise go to T0.
- HALT: all outputs 0 except ClearDP=0; Run=0; FSM stays in HALT until clear is asserted.

## Timing
- While clear=0: state=RESET, ClearDP=1, Run=0, every other output 0.
- After clear rises, the FSM spends exactly one full cycle in RESET, then enters T0. Run=1 from T0 onward.
- Outputs are a Moore decode of the state register and IR[31:27]. They settle after each rising edge and are sampled by the datapath on the next rising edge.
- Each T-step is exactly one cycle. Exception: ConFFQ combinationally gates PCin during br T6.
- IR is only decoded from T3 on, because IRin at T2 takes effect at the T2→T3 edge.
- Cycle counts per instruction, T0 inclusive:
  - 4: nop, halt, jr, in, out, mfhi, mflo
  - 5: neg, not, jal
  - 6: ALU ops, immediate ops, ldi
  - 7: mul, div, br
  - 8: ld, st
- Clear asserted mid-instruction: the FSM moves to RESET immediately (asynchronously), and all strobes drop in that same instant.
- Stop raised outside the last step has no effect until the next last step.

## Test plan
- Release clear → ClearDP=1 for one cycle, then T0 with PCout MARin IncPC Zlowin=1, Run=1.
- IR=addi R3,R4,-5 (0x61A7FFFB) → T3 Grb Rout Yin; T4 CSEout ADD Zlowin; T5 Zlowout Gra Rin; back to T0 at cycle 6.
- IR=ld opcode → 8 cycles; MARin at T5; RAMread at T6; Gra Rin at T7. IR=st → RAMwrite only at T7.
- IR=br, with ConFFQ=0 and then ConFFQ=1 → PCin at T6 equals 0 and 1 respectively; total 7 cycles.
- Stop=1 during the final step of add → HALT, Run=0, all outputs 0; the FSM stays in HALT until clear is pulsed.
- clear pulled low during ld T6 → RAMread and MDRin drop immediately; after release, RESET then T0.
